rx_frame_sync: RTL and testbench



---
 rtl/rx_frame_sync_pkg.sv | 15 +
 rtl/rx_bit_deser.sv | 31 +++
 rtl/rx_frame_sync.sv | 172 +++++++++++++++++
 tb/tb_rx_frame_sync.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_sync_pkg.sv
// Shared types and constants for the receive frame synchroniser.
package rx_frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_LEN     = 2'd2,
        ST_PAYLOAD = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_SYNC_WIDTH = 16;
    localparam logic [DEF_SYNC_WIDTH-1:0] DEF_SYNC_WORD = 16'h2DD4;
    localparam int unsigned LEN_WIDTH = 8;

endpackage

// File: rtl/rx_bit_deser.sv
// MSB-first bit-to-byte deserialiser shared by the length and payload phases.
module rx_bit_deser
    import rx_frame_sync_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en_i,
    input  logic                 clear_i,
    input  logic                 bit_in_i,
    output logic [LEN_WIDTH-1:0] byte_o,
    output logic                 byte_done_o
);

    logic [LEN_WIDTH-2:0] shift_q;
    logic [2:0]           cnt_q;

    // The eighth bit is presented combinationally so the caller can latch the full byte on that edge.
    assign byte_o      = {shift_q, bit_in_i};
    assign byte_done_o = shift_en_i && !clear_i && (cnt_q == 3'(LEN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en_i) begin
            shift_q <= byte_o[LEN_WIDTH-2:0];
            cnt_q   <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/rx_frame_sync.sv
// Sync-word hunt, length capture and payload deserialisation after packet detection.
module rx_frame_sync
    import rx_frame_sync_pkg::*;
#(
    parameter int unsigned              SYNC_WIDTH   = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0]    SYNC_WORD    = DEF_SYNC_WORD,
    parameter int unsigned              HUNT_TIMEOUT = 64,
    parameter int unsigned              CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic                 bit_in,
    input  logic                 PD_flag,
    output logic [LEN_WIDTH-1:0] byte_out,
    output logic                 byte_valid,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 len_valid,
    output logic                 pd_release,
    output logic                 rx_abort,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] HUNT_LIMIT = CNT_WIDTH'(HUNT_TIMEOUT);

    rx_state_e              state_q, state_d;
    logic [SYNC_WIDTH-1:0]  sync_q, sync_d, sync_shift;
    logic [CNT_WIDTH-1:0]   hunt_q, hunt_d, hunt_inc;
    logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [LEN_WIDTH-1:0]   frame_len_q, frame_len_d;
    logic [LEN_WIDTH-1:0]   byte_out_q, byte_out_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   len_valid_q, len_valid_d;
    logic                   release_q, release_d;
    logic                   abort_q, abort_d;
    logic                   deser_shift, deser_clear, deser_done;
    logic [LEN_WIDTH-1:0]   deser_byte;

    rx_bit_deser u_deser (
        .clk         (clk),
        .rst         (rst),
        .shift_en_i  (deser_shift),
        .clear_i     (deser_clear),
        .bit_in_i    (bit_in),
        .byte_o      (deser_byte),
        .byte_done_o (deser_done)
    );

    assign sync_shift   = {sync_q[SYNC_WIDTH-2:0], bit_in};
    assign hunt_inc     = (hunt_q == '1) ? hunt_q : hunt_q + 1'b1;
    assign byte_cnt_inc = byte_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        sync_d       = sync_q;
        hunt_d       = hunt_q;
        byte_cnt_d   = byte_cnt_q;
        frame_len_d  = frame_len_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        len_valid_d  = 1'b0;
        release_d    = 1'b0;
        abort_d      = 1'b0;
        deser_shift  = 1'b0;
        deser_clear  = 1'b0;

        if (clk_enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    deser_clear = 1'b1;
                    sync_d      = '0;
                    hunt_d      = '0;
                    if (PD_flag) begin
                        state_d = ST_HUNT;
                        sync_d  = {{(SYNC_WIDTH-1){1'b0}}, bit_in};
                        hunt_d  = CNT_WIDTH'(1);
                    end
                end
                ST_HUNT: begin
                    deser_clear = 1'b1;
                    if (!PD_flag) begin
                        state_d = ST_IDLE;
                    end else begin
                        sync_d = sync_shift;
                        // A match on the same bit that would expire the hunt still wins.
                        if (sync_shift == SYNC_WORD) begin
                            state_d = ST_LEN;
                        end else begin
                            hunt_d = hunt_inc;
                            if (hunt_inc >= HUNT_LIMIT) begin
                                release_d = 1'b1;
                                state_d   = ST_IDLE;
                            end
                        end
                    end
                end
                ST_LEN: begin
                    if (!PD_flag) begin
                        abort_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        deser_shift = 1'b1;
                        if (deser_done) begin
                            frame_len_d = deser_byte;
                            len_valid_d = 1'b1;
                            byte_cnt_d  = '0;
                            if (deser_byte == '0) begin
                                release_d = 1'b1;
                                state_d   = ST_IDLE;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!PD_flag) begin
                        abort_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        deser_shift = 1'b1;
                        if (deser_done) begin
                            byte_out_d   = deser_byte;
                            byte_valid_d = 1'b1;
                            byte_cnt_d   = byte_cnt_inc;
                            if (byte_cnt_inc == CNT_WIDTH'(frame_len_q)) begin
                                release_d = 1'b1;
                                state_d   = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            hunt_q       <= '0;
            byte_cnt_q   <= '0;
            frame_len_q  <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            len_valid_q  <= 1'b0;
            release_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            hunt_q       <= hunt_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_len_q  <= frame_len_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            len_valid_q  <= len_valid_d;
            release_q    <= release_d;
            abort_q      <= abort_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_len  = frame_len_q;
    assign len_valid  = len_valid_q;
    assign pd_release = release_q;
    assign rx_abort   = abort_q;
    assign busy       = (state_q == ST_LEN) || (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_rx_frame_sync.sv
// Scoreboard bench: expected output events are queued as frames are driven.
module tb_rx_frame_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_enable;
    logic       bit_in;
    logic       PD_flag;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [7:0] frame_len;
    logic       len_valid;
    logic       pd_release;
    logic       rx_abort;
    logic       busy;

    rx_frame_sync #(
        .SYNC_WIDTH   (16),
        .SYNC_WORD    (16'h2DD4),
        .HUNT_TIMEOUT (64),
        .CNT_WIDTH    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .bit_in     (bit_in),
        .PD_flag    (PD_flag),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_len  (frame_len),
        .len_valid  (len_valid),
        .pd_release (pd_release),
        .rx_abort   (rx_abort),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // flags = {byte_valid, len_valid, pd_release, rx_abort}
    typedef struct packed {
        logic [3:0] flags;
        logic [7:0] val;
    } ev_t;

    localparam logic [3:0] F_BYTE  = 4'b1000;
    localparam logic [3:0] F_LEN   = 4'b0100;
    localparam logic [3:0] F_REL   = 4'b0010;
    localparam logic [3:0] F_ABORT = 4'b0001;

    ev_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [3:0] flags, input logic [7:0] val);
        ev_t e;
        e.flags = flags;
        e.val   = val;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t obs;
        ev_t e;
        if (byte_valid || len_valid || pd_release || rx_abort) begin
            obs.flags = {byte_valid, len_valid, pd_release, rx_abort};
            obs.val   = byte_valid ? byte_out : (len_valid ? frame_len : 8'h00);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", 32'(obs), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("event_flags", 32'(obs.flags), 32'(e.flags));
                check_eq("event_value", 32'(obs.val), 32'(e.val));
            end
        end
    end

    // One bit per four clocks; returns two negedges after the enabled edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in     = b;
        clk_enable = 1'b1;
        @(negedge clk);
        clk_enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_pre(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_bit(i[0]);
    endtask

    task automatic send_sync();
        logic [15:0] s;
        s = 16'h2DD4;
        for (int i = 15; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'h0);
        PD_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[5];
        rst        = 1'b1;
        clk_enable = 1'b0;
        bit_in     = 1'b0;
        PD_flag    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {byte_out, frame_len, 4'h0, byte_valid, len_valid, pd_release, rx_abort, 3'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        PD_flag = 1'b1;
        expect_ev(F_LEN, 8'h03);
        expect_ev(F_BYTE, 8'hA5);
        expect_ev(F_BYTE, 8'h3C);
        expect_ev(F_BYTE | F_REL, 8'hFF);
        send_pre(16);
        send_sync();
        check_eq("busy_after_sync", 32'(busy), 32'h1);
        send_byte(8'h03);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'hFF);
        check_eq("busy_after_frame", 32'(busy), 32'h0);
        drain("queue_basic");

        // Hunt timeout on the 64th bit
        PD_flag = 1'b1;
        expect_ev(F_REL, 8'h00);
        send_pre(63);
        check_eq("no_release_before_timeout", 32'(exp_q.size()), 32'h1);
        @(negedge clk);
        bit_in     = 1'b1;
        clk_enable = 1'b1;
        @(negedge clk);
        clk_enable = 1'b0;
        check_eq("timeout_release_timing", 32'(pd_release), 32'h1);
        PD_flag = 1'b0;
        @(negedge clk);
        check_eq("timeout_busy", 32'(busy), 32'h0);
        drain("queue_timeout");

        // Zero length
        PD_flag = 1'b1;
        expect_ev(F_LEN | F_REL, 8'h00);
        send_pre(16);
        send_sync();
        send_byte(8'h00);
        check_eq("zero_len_busy", 32'(busy), 32'h0);
        drain("queue_zero_len");

        // PD loss during third byte
        PD_flag = 1'b1;
        expect_ev(F_LEN, 8'h04);
        expect_ev(F_BYTE, 8'h81);
        expect_ev(F_BYTE, 8'h7E);
        expect_ev(F_ABORT, 8'h00);
        send_pre(16);
        send_sync();
        send_byte(8'h04);
        send_byte(8'h81);
        send_byte(8'h7E);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("busy_before_loss", 32'(busy), 32'h1);
        PD_flag = 1'b0;
        send_bit(1'b1);
        check_eq("busy_after_loss", 32'(busy), 32'h0);
        drain("queue_pd_loss");

        // Sync completes exactly on hunt bit 64
        PD_flag = 1'b1;
        expect_ev(F_LEN, 8'h01);
        expect_ev(F_BYTE | F_REL, 8'h77);
        send_pre(48);
        send_sync();
        check_eq("boundary_busy", 32'(busy), 32'h1);
        send_byte(8'h01);
        send_byte(8'h77);
        drain("queue_boundary");

        // Reset during byte 2 of a 5-byte frame, then a clean frame
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        PD_flag = 1'b1;
        expect_ev(F_LEN, 8'h05);
        expect_ev(F_BYTE, pl[0]);
        send_pre(16);
        send_sync();
        send_byte(8'h05);
        send_byte(pl[0]);
        send_bit(pl[1][7]);
        send_bit(pl[1][6]);
        send_bit(pl[1][5]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midframe_reset_outputs", {byte_out, frame_len, 4'h0, byte_valid, len_valid, pd_release, rx_abort, 3'h0, busy}, 32'h0);
        rst     = 1'b0;
        PD_flag = 1'b0;
        check_eq("queue_before_reset", 32'(exp_q.size()), 32'h0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("idle_after_reset", 32'(busy), 32'h0);
        PD_flag = 1'b1;
        expect_ev(F_LEN, 8'h01);
        expect_ev(F_BYTE | F_REL, 8'h5A);
        send_pre(16);
        send_sync();
        send_byte(8'h01);
        send_byte(8'h5A);
        check_eq("clean_frame_len", 32'(frame_len), 32'h1);
        check_eq("clean_frame_byte_hold", 32'(byte_out), 32'h5A);
        drain("queue_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
